// File: rtl/gcode_line_arbiter_if.sv
// Byte-stream bundle between the G-code line arbiter and its environment:
// per-requester byte channels, the UART transmit channel and the UART receive strobe.
interface gcode_line_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic                 rx_valid;
    logic [7:0]           rx_data;

    modport master (
        output req_valid, req_data, tx_ready, rx_valid, rx_data,
        input  req_ready, tx_valid, tx_data
    );

    modport slave (
        input  req_valid, req_data, tx_ready, rx_valid, rx_data,
        output req_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/gcode_line_arbiter.sv
// Line-atomic round-robin arbiter sharing one UART tx stream between G-code sources,
// releasing the link only after the controller answers "ok"/"error" or a timeout expires.
module gcode_line_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TO_W           = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    gcode_line_arbiter_if.slave  bus,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 ack_ok,
    output logic                 ack_err,
    output logic                 timeout
);
    localparam int         PTR_W  = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_O   = 8'h6F;
    localparam logic [7:0] CH_K   = 8'h6B;
    localparam logic [7:0] CH_E   = 8'h65;

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, WAIT_OK} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               ack_ok_q, ack_ok_d;
    logic               ack_err_q, ack_err_d;
    logic               timeout_q, timeout_d;
    logic [1:0]         m_len_q, m_len_d;
    logic [7:0]         m_c0_q, m_c0_d;
    logic [7:0]         m_c1_q, m_c1_d;

    logic               ok_evt, err_evt;
    logic               tx_take, can_accept, owner_valid;
    logic [7:0]         owner_data;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [PTR_W-1:0]   sel;
    logic               found;
    int                 idx;

    // Reply matcher only needs the line length (saturating) and its first two characters.
    always_comb begin
        m_len_d = m_len_q;
        m_c0_d  = m_c0_q;
        m_c1_d  = m_c1_q;
        ok_evt  = 1'b0;
        err_evt = 1'b0;
        if (bus.rx_valid && bus.rx_data != CH_CR) begin
            if (bus.rx_data == CH_LF) begin
                ok_evt  = (m_len_q == 2'd2) && (m_c0_q == CH_O) && (m_c1_q == CH_K);
                err_evt = (m_len_q != 2'd0) && (m_c0_q == CH_E);
                m_len_d = 2'd0;
            end else begin
                if (m_len_q == 2'd0) m_c0_d = bus.rx_data;
                if (m_len_q == 2'd1) m_c1_d = bus.rx_data;
                if (m_len_q != 2'd3) m_len_d = m_len_q + 2'd1;
            end
        end
    end

    // rr_ptr always holds the current owner, so it doubles as the data mux select.
    assign tx_take     = tx_valid_q && bus.tx_ready;
    assign can_accept  = !tx_valid_q || bus.tx_ready;
    assign owner_valid = bus.req_valid[rr_ptr_q];
    assign owner_data  = bus.req_data[{rr_ptr_q, 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        tx_valid_d  = tx_valid_q && !tx_take;
        tx_data_d   = tx_data_q;
        to_cnt_d    = to_cnt_q;
        ack_ok_d    = 1'b0;
        ack_err_d   = 1'b0;
        timeout_d   = 1'b0;
        req_ready_c = '0;
        found       = 1'b0;
        idx         = 0;
        sel         = '0;
        case (state_q)
            IDLE: begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (int'(rr_ptr_q) + k) % NUM_REQ;
                    sel = idx[PTR_W-1:0];
                    if (!found && bus.req_valid[sel]) begin
                        found        = 1'b1;
                        grant_d      = '0;
                        grant_d[sel] = 1'b1;
                        rr_ptr_d     = sel;
                        state_d      = SEND;
                    end
                end
            end
            SEND: begin
                if (can_accept) req_ready_c = grant_q;
                if (can_accept && owner_valid) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = owner_data;
                    if (owner_data == CH_LF) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tx_take) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_OK;
                end
            end
            WAIT_OK: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (ok_evt) begin
                    ack_ok_d = 1'b1;
                    grant_d  = '0;
                    state_d  = IDLE;
                end else if (err_evt) begin
                    ack_err_d = 1'b1;
                    grant_d   = '0;
                    state_d   = IDLE;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            to_cnt_q   <= '0;
            ack_ok_q   <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            m_len_q    <= 2'd0;
            m_c0_q     <= 8'h00;
            m_c1_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            to_cnt_q   <= to_cnt_d;
            ack_ok_q   <= ack_ok_d;
            ack_err_q  <= ack_err_d;
            timeout_q  <= timeout_d;
            m_len_q    <= m_len_d;
            m_c0_q     <= m_c0_d;
            m_c1_q     <= m_c1_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign grant         = grant_q;
    assign busy          = (state_q != IDLE);
    assign ack_ok        = ack_ok_q;
    assign ack_err       = ack_err_q;
    assign timeout       = timeout_q;
endmodule

// File: tb/tb_gcode_line_arbiter.sv
// Directed bench for gcode_line_arbiter: line transfer, round-robin, back-pressure,
// reply filtering, timeout and asynchronous reset, each scenario checking its own results.
module tb_gcode_line_arbiter;
    localparam int NR = 2;
    localparam int TO = 100;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [NR-1:0] grant;
    logic          busy, ack_ok, ack_err, timeout;

    gcode_line_arbiter_if #(.NUM_REQ(NR)) bus ();

    gcode_line_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .TO_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .grant(grant), .busy(busy),
        .ack_ok(ack_ok), .ack_err(ack_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    logic stop_feed = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive log of tx transfers and reply pulses, sampled on the falling edge.
    logic [7:0]    tx_log[$];
    int            tx_cyc[$];
    logic [NR-1:0] tx_own[$];
    int ok_cnt = 0, err_cnt = 0, to_cnt = 0;
    int last_ok_cyc = -1, last_err_cyc = -1, last_to_cyc = -1;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.tx_valid && bus.tx_ready) begin
                tx_log.push_back(bus.tx_data);
                tx_cyc.push_back(cyc);
                tx_own.push_back(grant);
            end
            if (ack_ok)  begin ok_cnt  = ok_cnt + 1;  last_ok_cyc  = cyc; end
            if (ack_err) begin err_cnt = err_cnt + 1; last_err_cyc = cyc; end
            if (timeout) begin to_cnt  = to_cnt + 1;  last_to_cyc  = cyc; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input string s, output int last_cyc);
        last_cyc = cyc;
        for (int j = 0; j < s.len(); j++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = s[j];
            last_cyc     = cyc;
            tick();
        end
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    // Drives both requesters from one process; each string is that requester's byte stream.
    task automatic feed2(input string s0, input string s1);
        int   k0 = 0, k1 = 0, guard = 0;
        logic a0, a1;
        while ((k0 < s0.len() || k1 < s1.len()) && guard < 3000 && !stop_feed) begin
            bus.req_valid[0]     = (k0 < s0.len());
            bus.req_data[7:0]    = (k0 < s0.len()) ? s0[k0] : 8'h00;
            bus.req_valid[1]     = (k1 < s1.len());
            bus.req_data[15:8]   = (k1 < s1.len()) ? s1[k1] : 8'h00;
            @(negedge clk);
            a0 = bus.req_valid[0] && bus.req_ready[0];
            a1 = bus.req_valid[1] && bus.req_ready[1];
            tick();
            if (a0) k0++;
            if (a1) k1++;
            guard++;
        end
        bus.req_valid = '0;
        bus.req_data  = '0;
        vectors++;
        if (guard >= 3000) begin
            errors++;
            $display("[TB] FAIL feed_budget: got %0d cycles, required < 3000", guard);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        vectors++; if (bus.tx_valid !== 1'b0)  begin errors++; $display("[TB] FAIL rst_tx_valid: got %b required 0", bus.tx_valid); end
        vectors++; if (bus.tx_data !== 8'h00)  begin errors++; $display("[TB] FAIL rst_tx_data: got %h required 00", bus.tx_data); end
        vectors++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rst_req_ready: got %b required 00", bus.req_ready); end
        vectors++; if (grant !== 2'b00)        begin errors++; $display("[TB] FAIL rst_grant: got %b required 00", grant); end
        vectors++; if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
        vectors++; if ({ack_ok, ack_err, timeout} !== 3'b000) begin errors++; $display("[TB] FAIL rst_pulses: got %b required 000", {ack_ok, ack_err, timeout}); end
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_line();
        int base = tx_log.size();
        int okb  = ok_cnt;
        int nl;
        string exp_s = "G90\n";
        logic [7:0] eb;
        bus.tx_ready = 1'b1;
        feed2("G90\n", "");
        vectors++; if (bus.req_ready[0] !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_drop: got %b required 0", bus.req_ready[0]); end
        tick(); tick();
        vectors++; if (tx_log.size() !== base + 4) begin errors++; $display("[TB] FAIL single_count: got %0d required %0d", tx_log.size() - base, 4); end
        for (int j = 0; j < 4 && base + j < tx_log.size(); j++) begin
            eb = exp_s[j];
            vectors++; if (tx_log[base+j] !== eb) begin errors++; $display("[TB] FAIL single_byte%0d: got %h required %h", j, tx_log[base+j], eb); end
            if (j > 0) begin
                vectors++; if (tx_cyc[base+j] !== tx_cyc[base+j-1] + 1) begin errors++; $display("[TB] FAIL single_gap%0d: got cycle %0d required %0d", j, tx_cyc[base+j], tx_cyc[base+j-1] + 1); end
            end
        end
        send_rx("ok\r\n", nl);
        tick(); tick();
        vectors++; if (ok_cnt !== okb + 1)   begin errors++; $display("[TB] FAIL single_ok_count: got %0d required %0d", ok_cnt - okb, 1); end
        vectors++; if (last_ok_cyc !== nl + 1) begin errors++; $display("[TB] FAIL single_ok_cycle: got %0d required %0d", last_ok_cyc, nl + 1); end
        vectors++; if (grant !== 2'b00)      begin errors++; $display("[TB] FAIL single_grant_release: got %b required 00", grant); end
        vectors++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL single_busy: got %b required 0", busy); end
    endtask

    function automatic int count_nl(input int from);
        int n = 0;
        for (int j = from; j < tx_log.size(); j++) if (tx_log[j] == 8'h0A) n++;
        return n;
    endfunction

    task automatic test_arbitration();
        int base, okb, dummy;
        string exp_s = "M3\nG0\nM5\nG1\n";
        logic [NR-1:0] exp_own[12] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01,
                                       2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
        logic [7:0] eb;
        reset = 1'b0;
        tick(); tick();
        base = tx_log.size();
        okb  = ok_cnt;
        bus.tx_ready = 1'b1;
        reset = 1'b1;
        fork
            feed2("G0\nG1\n", "M3\nM5\n");
            begin
                for (int n = 0; n < 4; n++) begin
                    int g = 0;
                    while (count_nl(base) < n + 1 && g < 500) begin tick(); g++; end
                    vectors++; if (g >= 500) begin errors++; $display("[TB] FAIL arb_line%0d_wait: got %0d lines required %0d", n, count_nl(base), n + 1); end
                    tick();
                    send_rx("ok\n", dummy);
                end
            end
        join
        tick(); tick();
        vectors++; if (tx_log.size() !== base + 12) begin errors++; $display("[TB] FAIL arb_count: got %0d required 12", tx_log.size() - base); end
        for (int j = 0; j < 12 && base + j < tx_log.size(); j++) begin
            eb = exp_s[j];
            vectors++; if (tx_log[base+j] !== eb) begin errors++; $display("[TB] FAIL arb_byte%0d: got %h required %h", j, tx_log[base+j], eb); end
            vectors++; if (tx_own[base+j] !== exp_own[j]) begin errors++; $display("[TB] FAIL arb_owner%0d: got %b required %b", j, tx_own[base+j], exp_own[j]); end
        end
        vectors++; if (ok_cnt !== okb + 4) begin errors++; $display("[TB] FAIL arb_ok_count: got %0d required 4", ok_cnt - okb); end
    endtask

    task automatic test_back_pressure();
        int base = tx_log.size();
        int dummy;
        string exp_s = "G21\n";
        logic [7:0] eb;
        fork
            feed2("G21\n", "");
            begin
                int k = 0;
                logic prev_stall = 1'b0;
                logic [7:0] prev_data = 8'h00;
                while (tx_log.size() < base + 4 && k < 300) begin
                    bus.tx_ready = (k % 4 == 0) || (k % 4 == 3);
                    @(negedge clk);
                    if (prev_stall) begin
                        vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin errors++; $display("[TB] FAIL bp_hold: got valid %b data %h required valid 1 data %h", bus.tx_valid, bus.tx_data, prev_data); end
                    end
                    if (bus.tx_valid && !bus.tx_ready) begin
                        vectors++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL bp_ready_low: got %b required 00", bus.req_ready); end
                    end
                    prev_stall = bus.tx_valid && !bus.tx_ready;
                    prev_data  = bus.tx_data;
                    tick();
                    k++;
                end
                bus.tx_ready = 1'b1;
            end
        join
        tick(); tick(); tick();
        vectors++; if (tx_log.size() !== base + 4) begin errors++; $display("[TB] FAIL bp_count: got %0d required 4", tx_log.size() - base); end
        for (int j = 0; j < 4 && base + j < tx_log.size(); j++) begin
            eb = exp_s[j];
            vectors++; if (tx_log[base+j] !== eb) begin errors++; $display("[TB] FAIL bp_byte%0d: got %h required %h", j, tx_log[base+j], eb); end
        end
        send_rx("ok\n", dummy);
        tick(); tick();
    endtask

    task automatic test_reply_filter();
        int okb = ok_cnt;
        int erb = err_cnt;
        int nl;
        bus.tx_ready = 1'b1;
        feed2("G4\n", "");
        tick(); tick();
        send_rx("<Idle|MPos:0,0,0>\n", nl);
        tick();
        vectors++; if (ok_cnt !== okb || err_cnt !== erb) begin errors++; $display("[TB] FAIL filter_status_line: got ok %0d err %0d required 0 0", ok_cnt - okb, err_cnt - erb); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL filter_still_waiting: got %b required 1", busy); end
        send_rx("error:20\n", nl);
        tick(); tick();
        vectors++; if (err_cnt !== erb + 1) begin errors++; $display("[TB] FAIL filter_err_count: got %0d required 1", err_cnt - erb); end
        vectors++; if (last_err_cyc !== nl + 1) begin errors++; $display("[TB] FAIL filter_err_cycle: got %0d required %0d", last_err_cyc, nl + 1); end
        vectors++; if (ok_cnt !== okb) begin errors++; $display("[TB] FAIL filter_no_ok: got %0d required 0", ok_cnt - okb); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL filter_idle: got %b required 0", busy); end
        send_rx("ok\n", nl);
        tick(); tick();
        vectors++; if (ok_cnt !== okb) begin errors++; $display("[TB] FAIL filter_idle_ok: got %0d pulses required 0", ok_cnt - okb); end
    endtask

    task automatic test_timeout();
        int tob = to_cnt;
        int okb = ok_cnt;
        int c, nl, g;
        bus.tx_ready = 1'b1;
        feed2("G0\n", "");
        tick();
        c = tx_cyc[tx_cyc.size()-1];
        g = 0;
        while (to_cnt == tob && g < 200) begin tick(); g++; end
        tick();
        vectors++; if (to_cnt !== tob + 1) begin errors++; $display("[TB] FAIL to_count: got %0d required 1", to_cnt - tob); end
        vectors++; if (last_to_cyc !== c + 101) begin errors++; $display("[TB] FAIL to_cycle: got %0d required %0d", last_to_cyc, c + 101); end
        vectors++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("[TB] FAIL to_idle: got busy %b grant %b required 0 00", busy, grant); end
        vectors++; if (ok_cnt !== okb) begin errors++; $display("[TB] FAIL to_no_ok: got %0d required 0", ok_cnt - okb); end

        tob = to_cnt;
        feed2("G0\n", "");
        tick();
        c = tx_cyc[tx_cyc.size()-1];
        while (cyc < c + 98) tick();
        send_rx("ok\n", nl);
        tick(); tick(); tick();
        vectors++; if (ok_cnt !== okb + 1) begin errors++; $display("[TB] FAIL to_race_ok: got %0d required 1", ok_cnt - okb); end
        vectors++; if (last_ok_cyc !== c + 101) begin errors++; $display("[TB] FAIL to_race_cycle: got %0d required %0d", last_ok_cyc, c + 101); end
        vectors++; if (to_cnt !== tob) begin errors++; $display("[TB] FAIL to_race_no_timeout: got %0d required 0", to_cnt - tob); end
    endtask

    task automatic test_reset_mid_line();
        int base = tx_log.size();
        int okb, dummy;
        string exp_s = "G2\n";
        logic [7:0] eb;
        bus.tx_ready = 1'b1;
        fork
            feed2("", "G1 X0\n");
            begin
                int g = 0;
                while (tx_log.size() < base + 2 && g < 200) begin tick(); g++; end
                @(negedge clk);
                #2;
                reset     = 1'b0;
                stop_feed = 1'b1;
                #1;
                vectors++; if (bus.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_tx_valid: got %b required 0", bus.tx_valid); end
                vectors++; if (bus.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_tx_data: got %h required 00", bus.tx_data); end
                vectors++; if (grant !== 2'b00)       begin errors++; $display("[TB] FAIL mid_rst_grant: got %b required 00", grant); end
                vectors++; if (busy !== 1'b0)         begin errors++; $display("[TB] FAIL mid_rst_busy: got %b required 0", busy); end
                vectors++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL mid_rst_req_ready: got %b required 00", bus.req_ready); end
            end
        join
        tick(); tick();
        reset     = 1'b1;
        stop_feed = 1'b0;
        base = tx_log.size();
        okb  = ok_cnt;
        feed2("G2\n", "");
        tick(); tick();
        vectors++; if (tx_log.size() !== base + 3) begin errors++; $display("[TB] FAIL fresh_count: got %0d required 3", tx_log.size() - base); end
        for (int j = 0; j < 3 && base + j < tx_log.size(); j++) begin
            eb = exp_s[j];
            vectors++; if (tx_log[base+j] !== eb) begin errors++; $display("[TB] FAIL fresh_byte%0d: got %h required %h", j, tx_log[base+j], eb); end
            vectors++; if (tx_own[base+j] !== 2'b01) begin errors++; $display("[TB] FAIL fresh_owner%0d: got %b required 01", j, tx_own[base+j]); end
        end
        send_rx("ok\n", dummy);
        tick(); tick();
        vectors++; if (ok_cnt !== okb + 1) begin errors++; $display("[TB] FAIL fresh_ok: got %0d required 1", ok_cnt - okb); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        test_reset();
        test_single_line();
        test_arbitration();
        test_back_pressure();
        test_reply_filter();
        test_timeout();
        test_reset_mid_line();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: got time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/gcode_line_arbiter.md
Name: gcode_line_arbiter

Overview:
- Shares the single UART transmit byte stream between NUM_REQ G-code byte sources, such as a homing/setup sequence source and a move-command source.
- Arbitration is line-atomic: once granted, a requester owns the link until its '\n' byte has been sent.
- After each line the block parses the controller's UART receive stream and waits for an "ok" (or "error...") reply, or a timeout, before granting the next line. This gives per-line flow control to the firmware.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 50_000_000, clk cycles to wait for a reply before declaring the line lost.
- TO_W, 32, width of the timeout counter.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  output  NUM_REQ  per-requester byte accept.
- tx_valid  output  1  byte valid toward the UART transmitter.
- tx_data  output  8  byte toward the UART transmitter.
- tx_ready  input  1  UART transmitter can accept a byte.
- rx_valid  input  1  one-cycle strobe: received byte from the controller.
- rx_data  input  8  received byte.
- grant  output  NUM_REQ  one-hot current owner; 0 when no owner.
- busy  output  1  high whenever state is not IDLE.
- ack_ok  output  1  one-cycle pulse: "ok" received for the outstanding line.
- ack_err  output  1  one-cycle pulse: error line received for the outstanding line.
- timeout  output  1  one-cycle pulse: reply wait expired.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE;
  - tx_valid=0, tx_data=0;
  - req_ready=0, grant=0, busy=0;
  - ack_ok=0, ack_err=0, timeout=0;
  - rr_ptr=0, rx matcher cleared, timeout counter=0.
- Reset asserted mid-line or mid-wait aborts with no further output. A partially sent line is not resumed.
- Transfers: on the tx side, a byte moves when tx_valid&&tx_ready. On requester i, a byte moves when req_valid[i]&&req_ready[i].
- tx_valid and tx_data are registered. A requester byte accepted in cycle t appears on tx_data in cycle t+1.
- tx_valid stays high, with tx_data stable, until tx_ready.
- State IDLE:
  - If any req_valid is high, grant the first requester with req_valid high, searching from index rr_ptr+1 modulo NUM_REQ.
  - Set grant one-hot, set rr_ptr to the winner, go to SEND.
  - No byte is accepted in the grant cycle.
- State SEND:
  - req_ready[g] = (!tx_valid || tx_ready) && !eol_seen. All other req_ready bits are 0.
  - Each accepted byte loads tx_data and sets tx_valid.
  - If the accepted byte is 0x0A, set eol_seen and go to DRAIN.
  - If the owner drops req_valid mid-line, the grant is held indefinitely. There is no preemption.
- State DRAIN:
  - Hold until the '\n' byte is taken (tx_valid&&tx_ready).
  - Then clear tx_valid, clear the timeout counter, go to WAIT_OK.
- State WAIT_OK:
  - grant remains at the owner.
  - The timeout counter increments every cycle.
  - On a matcher "ok" event: pulse ack_ok, then go to IDLE with grant=0.
  - On a matcher "err" event: pulse ack_err, then go to IDLE with grant=0.
  - When the counter reaches TIMEOUT_CYCLES-1 with no event: pulse timeout, then go to IDLE with grant=0.
  - If an event and expiry occur in the same cycle, the event wins and timeout is not pulsed.
- The rx line matcher runs in all states:
  - 0x0D is ignored.
  - On 0x0A the matcher classifies the line just ended:
    - exactly "ok" gives an "ok" event;
    - a first character of 'e' gives an "err" event;
    - anything else (status "<...>", "[MSG...]", blank) is discarded.
  - The matcher then resets for the next line.
  - Events that occur outside WAIT_OK are discarded; no pulse is produced.
  - Events are evaluated in the same cycle as the rx_valid byte that carries '\n'. ack_* rises in the following cycle.
- Fairness: after requester i completes a line, another waiting requester is granted before i is granted again.
- busy = (state != IDLE).

Test Plan:
- Single line: req0 sends "G90\n" with tx_ready held 1; rx returns "ok\r\n".
  - tx emits 0x47,0x39,0x30,0x0A on consecutive cycles.
  - req_ready[0] drops after 0x0A is accepted.
  - ack_ok pulses once, one cycle after the rx 0x0A; grant returns to 0.
- Arbitration: req0 and req1 both valid from reset release, each sending 2 lines, each line acknowledged with "ok\n".
  - Grant order is req1, req0, req1, req0 (rr_ptr starts at 0).
  - No byte from one requester is interleaved inside another requester's line.
- Back-pressure: tx_ready toggles 1,0,0,1,... during "G21\n".
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - No byte is lost or duplicated.
  - req_ready stays 0 while the tx register is full and not draining.
- Reply filtering: during WAIT_OK the rx stream is "<Idle|MPos:0,0,0>\n" then "error:20\n".
  - The first line produces no pulse.
  - ack_err pulses once; ack_ok never pulses.
  - An "ok\n" received while the block is in IDLE produces no pulse.
- Timeout: TIMEOUT_CYCLES=100, no rx traffic after the line is sent.
  - timeout pulses exactly 100 cycles after WAIT_OK entry, then state is IDLE.
  - An "ok\n" arriving on the expiry cycle produces ack_ok and no timeout pulse.
- Reset mid-line: assert reset after 2 bytes of "G1 X0\n" have been sent.
  - All outputs go to 0 immediately, without waiting for a clk edge.
  - After release, the next grant starts a fresh line.
